// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder: stage-count helper, parameter sanity
// check and the per-stage bookkeeping flags carried between pipeline stages.
package add_pkg;

    function automatic int nstg(input int width, input int slice_w, input int sps);
        return width / (slice_w * sps);
    endfunction

    function automatic bit cfg_ok(input int width, input int slice_w, input int sps);
        return (width > 0) && (slice_w > 0) && (sps > 0) && (width % (slice_w * sps) == 0);
    endfunction

    // Carry into the next stage plus the operand sign bits that the final stage needs for ov.
    typedef struct packed {
        logic cy;
        logic a_msb;
        logic b_msb;
    } stage_flags_t;

endpackage

// File: rtl/addn_pipe_if.sv
// Operand/result handshake bundle of addn_pipe; the producer/consumer side is the master.
interface addn_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic             ci;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    logic             zero;

    modport master (
        output in_valid, sub, ci, a, b, out_ready,
        input  in_ready, out_valid, s, co, ov, zero
    );

    modport slave (
        input  in_valid, sub, ci, a, b, out_ready,
        output in_ready, out_valid, s, co, ov, zero
    );
endinterface

// File: rtl/add_slice.sv
// Combinational W-bit ripple-carry adder slice.
module add_slice #(
    parameter int W = 4
) (
    input  logic         ci,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         co
);
    always_comb begin
        logic c;
        // NOTE: the ripple carry is a blocking temporary inside always_comb; each
        // iteration must see the carry produced by the previous bit in the same pass.
        s = '0;
        c = ci;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

// File: rtl/addn_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: each stage adds SLICE_W*SPS bits and forwards
// the partial sum, the unprocessed operand bits and its carry to the next stage.
module addn_pipe
    import add_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 4,
    parameter int SPS     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    addn_pipe_if.slave bus
);
    localparam int SW   = SLICE_W * SPS;
    localparam int NSTG = nstg(WIDTH, SLICE_W, SPS);

    if (!cfg_ok(WIDTH, SLICE_W, SPS)) begin : g_cfg_err
        $error("addn_pipe: WIDTH must be a positive multiple of SLICE_W*SPS");
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int IN_W = WIDTH - k * SW;   // operand bits still unprocessed on entry
        localparam int LO_W = (k + 1) * SW;     // sum bits known on exit

        logic            vld_q;
        logic            load;
        logic            move;
        logic            src_vld;
        logic [IN_W-1:0] op_a;
        logic [IN_W-1:0] op_b;
        logic            cin;
        logic            a_msb;
        logic            b_msb;
        logic [SW-1:0]   sl_s;
        logic            cy_out;
        logic [LO_W-1:0] sum_nx;

        if (k == 0) begin : g_src
            // b is inverted here once; later stages only ever see b'.
            assign src_vld = bus.in_valid;
            assign op_a    = bus.a;
            assign op_b    = bus.sub ? ~bus.b : bus.b;
            assign cin     = bus.sub | bus.ci;
            assign a_msb   = bus.a[WIDTH-1];
            assign b_msb   = op_b[IN_W-1];
            assign sum_nx  = sl_s;
        end else begin : g_src
            assign src_vld = g_stg[k-1].vld_q;
            assign op_a    = g_stg[k-1].g_mid.q.hi_a;
            assign op_b    = g_stg[k-1].g_mid.q.hi_b;
            assign cin     = g_stg[k-1].g_mid.q.fl.cy;
            assign a_msb   = g_stg[k-1].g_mid.q.fl.a_msb;
            assign b_msb   = g_stg[k-1].g_mid.q.fl.b_msb;
            assign sum_nx  = {sl_s, g_stg[k-1].g_mid.q.lo_sum};
        end

        for (genvar j = 0; j < SPS; j++) begin : g_sl
            logic c_in;
            logic c_out;

            if (j == 0) begin : g_ci
                assign c_in = cin;
            end else begin : g_ci
                assign c_in = g_sl[j-1].c_out;
            end

            add_slice #(.W(SLICE_W)) u_slice (
                .ci (c_in),
                .a  (op_a[j*SLICE_W +: SLICE_W]),
                .b  (op_b[j*SLICE_W +: SLICE_W]),
                .s  (sl_s[j*SLICE_W +: SLICE_W]),
                .co (c_out)
            );
        end
        assign cy_out = g_sl[SPS-1].c_out;

        // A stage takes a new beat when it is empty or its current beat leaves this cycle.
        assign load = ~vld_q | move;
        if (k == NSTG - 1) begin : g_rdy
            assign move = vld_q & bus.out_ready;
        end else begin : g_rdy
            assign move = vld_q & g_stg[k+1].load;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else if (load) begin
                vld_q <= src_vld;
            end
        end

        if (k < NSTG - 1) begin : g_mid
            typedef struct packed {
                logic [IN_W-SW-1:0] hi_a;
                logic [IN_W-SW-1:0] hi_b;
                logic [LO_W-1:0]    lo_sum;
                stage_flags_t       fl;
            } stage_t;

            stage_t q;

            // NOTE: the data registers are reset too, so every stage holds zero out of
            // reset rather than X; this is a handful of flops per stage, not a memory.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (load && src_vld) begin
                    q.hi_a     <= op_a[IN_W-1:SW];
                    q.hi_b     <= op_b[IN_W-1:SW];
                    q.lo_sum   <= sum_nx;
                    q.fl.cy    <= cy_out;
                    q.fl.a_msb <= a_msb;
                    q.fl.b_msb <= b_msb;
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] s_q;
            logic             co_q;
            logic             ov_q;
            logic             zero_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_q    <= '0;
                    co_q   <= 1'b0;
                    ov_q   <= 1'b0;
                    zero_q <= 1'b0;
                end else if (load && src_vld) begin
                    s_q    <= sum_nx;
                    co_q   <= cy_out;
                    ov_q   <= (a_msb == b_msb) && (sum_nx[WIDTH-1] != a_msb);
                    zero_q <= (sum_nx == '0);
                end
            end
        end
    end

    assign bus.in_ready  = g_stg[0].load;
    assign bus.out_valid = g_stg[NSTG-1].vld_q;
    assign bus.s         = g_stg[NSTG-1].g_last.s_q;
    assign bus.co        = g_stg[NSTG-1].g_last.co_q;
    assign bus.ov        = g_stg[NSTG-1].g_last.ov_q;
    assign bus.zero      = g_stg[NSTG-1].g_last.zero_q;

endmodule

// File: tb/tb_addn_pipe.sv
// Directed-vector bench for addn_pipe: 32-bit/SPS=2 instance plus a 16-bit/SPS=1 instance.
module tb_addn_pipe;
    localparam int NSTG = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addn_pipe_if #(.WIDTH(32)) bus ();
    addn_pipe_if #(.WIDTH(16)) bus16 ();

    addn_pipe #(.WIDTH(32), .SLICE_W(4), .SPS(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    addn_pipe #(.WIDTH(16), .SLICE_W(4), .SPS(1)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    typedef struct {
        logic        sub;
        logic        ci;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        zero;
    } vec_t;

    vec_t tbl[$];
    vec_t expq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cycles;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input logic co, input logic ov, input logic zero,
                                       input logic [31:0] s);
        return {29'd0, co, ov, zero, s};
    endfunction

    function automatic vec_t dv(input logic sub, input logic ci, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] s, input logic co,
                                input logic ov, input logic zero);
        vec_t v;
        v.sub = sub; v.ci = ci; v.a = a; v.b = b;
        v.s = s; v.co = co; v.ov = ov; v.zero = zero;
        return v;
    endfunction

    // Reference arithmetic for generated vectors.
    function automatic vec_t mk(input logic sub, input logic ci, input logic [31:0] a,
                                input logic [31:0] b);
        vec_t        v;
        logic [31:0] bb;
        logic [32:0] full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : ci)};
        v = dv(sub, ci, a, b, full[31:0], full[32],
               (a[31] == bb[31]) && (full[31] != a[31]), full[31:0] == 32'd0);
        return v;
    endfunction

    // Streams tbl through the DUT; mode 0: out_ready always 1, mode 1: out_ready 1,0,0,1.
    task automatic stream(input int mode, output int ncyc);
        int idx = 0;
        int cyc = 0;
        while ((idx < tbl.size() || expq.size() != 0) && cyc < 2000) begin
            bus.in_valid = (idx < tbl.size());
            if (idx < tbl.size()) begin
                bus.sub = tbl[idx].sub;
                bus.ci  = tbl[idx].ci;
                bus.a   = tbl[idx].a;
                bus.b   = tbl[idx].b;
            end
            bus.out_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            #4;
            check("in_ready", 64'(bus.in_ready), 64'((expq.size() < NSTG) || bus.out_ready));
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_out_valid", 64'(bus.out_valid), 64'(0));
                end else if (bus.out_ready) begin
                    check("out_beat", pk(bus.co, bus.ov, bus.zero, bus.s),
                          pk(expq[0].co, expq[0].ov, expq[0].zero, expq[0].s));
                    void'(expq.pop_front());
                end else begin
                    check("stall_hold", pk(bus.co, bus.ov, bus.zero, bus.s),
                          pk(expq[0].co, expq[0].ov, expq[0].zero, expq[0].s));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(tbl[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_drained", 64'(expq.size() + (tbl.size() - idx)), 64'(0));
        expq.delete();
        ncyc = cyc;
    endtask

    task automatic beat32(input vec_t v);
        check("idle_in_ready", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1; bus.sub = v.sub; bus.ci = v.ci; bus.a = v.a; bus.b = v.b;
        bus.out_ready = 1'b1;
        for (int e = 1; e <= NSTG; e++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check($sformatf("lat32_edge%0d", e), 64'(bus.out_valid), 64'(e == NSTG));
        end
        check("beat32", pk(bus.co, bus.ov, bus.zero, bus.s), pk(v.co, v.ov, v.zero, v.s));
        @(posedge clk);
        #1;
        check("beat32_consumed", 64'(bus.out_valid), 64'(0));
    endtask

    task automatic beat16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                          input logic co, input logic ov, input logic zero);
        bus16.in_valid = 1'b1; bus16.sub = 1'b0; bus16.ci = 1'b0; bus16.a = a; bus16.b = b;
        bus16.out_ready = 1'b1;
        for (int e = 1; e <= NSTG; e++) begin
            @(posedge clk);
            #1;
            bus16.in_valid = 1'b0;
            check($sformatf("lat16_edge%0d", e), 64'(bus16.out_valid), 64'(e == NSTG));
        end
        check("beat16", pk(bus16.co, bus16.ov, bus16.zero, {16'd0, bus16.s}),
              pk(co, ov, zero, {16'd0, s}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.sub = 1'b0; bus.ci = 1'b0; bus.a = '0; bus.b = '0;
        bus.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.sub = 1'b0; bus16.ci = 1'b0; bus16.a = '0; bus16.b = '0;
        bus16.out_ready = 1'b1;

        // Reset and idle.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_outputs", pk(bus.co, bus.ov, bus.zero, bus.s), pk(1'b0, 1'b0, 1'b0, 32'd0));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_out_valid", 64'(bus.out_valid), 64'(0));
        end

        // Single beat with latency.
        beat32(dv(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1));

        // Directed add/sub table.
        tbl.delete();
        tbl.push_back(dv(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1));
        tbl.push_back(dv(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(dv(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        tbl.push_back(dv(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        tbl.push_back(dv(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_678A, 1'b0, 1'b0, 1'b0));
        tbl.push_back(dv(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0, 1'b1));
        tbl.push_back(dv(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1));
        tbl.push_back(dv(1'b1, 1'b1, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b0, 1'b0));
        tbl.push_back(dv(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
        tbl.push_back(dv(1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0));
        stream(0, cycles);

        // Every 4-bit slice pattern, back to back: one result per cycle after the fill.
        tbl.delete();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    tbl.push_back(mk(1'b0, c[0], {8{x[3:0]}}, {8{y[3:0]}}));
        stream(0, cycles);
        check("sweep_cycles", 64'(cycles), 64'(512 + NSTG));

        // Backpressure stream.
        tbl.delete();
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(i[0], (i % 3) == 0, 32'h1357_9BDF * (i + 1), 32'h0F0F_F0F0 + i));
        stream(1, cycles);

        // Reset with three beats in flight, the oldest stalled at the output.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.sub = 1'b0; bus.ci = 1'b0;
            bus.a = 32'h100 * (i + 1); bus.b = 32'h1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
        check("pre_rst_beat", pk(bus.co, bus.ov, bus.zero, bus.s), pk(1'b0, 1'b0, 1'b0, 32'h101));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("async_rst_outputs", pk(bus.co, bus.ov, bus.zero, bus.s), pk(1'b0, 1'b0, 1'b0, 32'd0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_beat", 64'(bus.out_valid), 64'(0));
        end

        // 16-bit, one slice per stage.
        beat16(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        beat16(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
